multdiv_unit: RTL and testbench



---
 rtl/multdiv_unit.sv | 236 +++++++++++++++++++++++
 tb/tb_multdiv_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_unit.sv
// -----------------------------------------------------------------------------
// multdiv_unit
//
// Multi-cycle signed multiply/divide unit sitting beside the execute stage.
// A start pulse captures both operands and the operation, then the unit
// iterates once per clock for WIDTH cycles and presents the result for
// exactly one cycle. Latency is fixed at WIDTH cycles from the start edge,
// including the divide-by-zero and overflow cases.
//
// Multiply: radix-2 Booth over a 2*WIDTH+1-bit product register.
// Divide:   restoring division on operand magnitudes, sign fixed up at the end.
//
// Ports
//   clock           rising-edge clock
//   reset           asynchronous, active-high; forces IDLE
//   ctrl_MULT       one-cycle start pulse, signed multiply (wins over DIV)
//   ctrl_DIV        one-cycle start pulse, signed divide
//   data_operandA   multiplicand / dividend, sampled on the start edge only
//   data_operandB   multiplier / divisor, sampled on the start edge only
//   data_result     product low word or quotient, 0 outside the DONE cycle
//   data_exception  overflow or divide-by-zero, 0 outside the DONE cycle
//   data_resultRDY  one-cycle completion strobe (DONE state)
//   busy            high in RUN and DONE; pipeline stall request
// -----------------------------------------------------------------------------
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam int PW = 2 * WIDTH + 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [CW-1:0]    count_reg;
    logic             op_mult_reg;

    // Multiply datapath
    logic [PW-1:0]    prod_reg;
    logic [WIDTH-1:0] mcand_reg;

    // Divide datapath
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic             neg_reg;
    logic             div_zero_reg;
    logic             div_ovf_reg;

    logic             start;
    logic             last_step;

    assign start     = ctrl_MULT | ctrl_DIV;
    assign last_step = (count_reg == LAST_COUNT);

    // -------------------------------------------------------------------------
    // Booth step. The accumulator half is sign-extended by one bit before the
    // add/subtract so that subtracting the most negative multiplicand cannot
    // overflow; the extra bit becomes the new top bit after the implicit
    // arithmetic shift right.
    // -------------------------------------------------------------------------
    logic [WIDTH:0] booth_acc;
    logic [WIDTH:0] mcand_ext;
    logic [WIDTH:0] booth_sum;
    logic [PW-1:0]  booth_next;

    always_comb begin
        booth_acc = {prod_reg[PW-1], prod_reg[PW-1:WIDTH+1]};
        mcand_ext = {mcand_reg[WIDTH-1], mcand_reg};
        booth_sum = booth_acc;
        case (prod_reg[1:0])
            2'b01:   booth_sum = booth_acc + mcand_ext;
            2'b10:   booth_sum = booth_acc - mcand_ext;
            default: booth_sum = booth_acc;
        endcase
        booth_next = {booth_sum, prod_reg[WIDTH:1]};
    end

    // -------------------------------------------------------------------------
    // Restoring division step: shift the next dividend bit into the partial
    // remainder and keep the difference only when it did not go negative.
    // The remainder is always below the divisor, so WIDTH+1 bits suffice for
    // the trial subtraction and its sign bit.
    // -------------------------------------------------------------------------
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_fits;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    always_comb begin
        div_shift = {rem_reg, quo_reg[WIDTH-1]};
        div_diff  = div_shift - {1'b0, divisor_reg};
        div_fits  = ~div_diff[WIDTH];
        rem_next  = div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        quo_next  = {quo_reg[WIDTH-2:0], div_fits};
    end

    // Operand magnitudes for the divider; the most negative value maps onto
    // itself, which is the correct unsigned magnitude.
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and status outputs. A start pulse restarts from any state,
    // which is how an in-flight op gets flushed.
    always_comb begin
        state_next     = state_reg;
        busy           = 1'b0;
        data_resultRDY = 1'b0;

        case (state_reg)
            IDLE: state_next = IDLE;
            RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy           = 1'b1;
                data_resultRDY = 1'b1;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (start) begin
            state_next = RUN;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg    <= '0;
            op_mult_reg  <= 1'b0;
            prod_reg     <= '0;
            mcand_reg    <= '0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            divisor_reg  <= '0;
            neg_reg      <= 1'b0;
            div_zero_reg <= 1'b0;
            div_ovf_reg  <= 1'b0;
        end else if (start) begin
            count_reg   <= '0;
            op_mult_reg <= ctrl_MULT;
            if (ctrl_MULT) begin
                // Accumulator cleared, multiplier in the middle, Booth guard bit 0.
                prod_reg  <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
                mcand_reg <= data_operandA;
            end else begin
                rem_reg      <= '0;
                quo_reg      <= a_mag;
                divisor_reg  <= b_mag;
                neg_reg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                div_zero_reg <= (data_operandB == '0);
                div_ovf_reg  <= (data_operandA == MOST_NEG) && (&data_operandB);
            end
        end else if (state_reg == RUN) begin
            count_reg <= count_reg + 1'b1;
            if (op_mult_reg) begin
                prod_reg <= booth_next;
            end else begin
                rem_reg <= rem_next;
                quo_reg <= quo_next;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Result formatting. The full product lives in prod_reg[PW-1:1]; it fits
    // in WIDTH bits only if its top WIDTH+1 bits are all copies of the sign.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] mult_result;
    logic             mult_exc;
    logic [WIDTH-1:0] div_result;
    logic             div_exc;

    always_comb begin
        mult_result = prod_reg[WIDTH:1];
        mult_exc    = ~((&prod_reg[PW-1:WIDTH]) | ~(|prod_reg[PW-1:WIDTH]));
        div_exc     = div_zero_reg | div_ovf_reg;
        if (div_zero_reg) begin
            div_result = '0;
        end else if (neg_reg) begin
            div_result = -quo_reg;
        end else begin
            div_result = quo_reg;
        end
    end

    always_comb begin
        data_result    = '0;
        data_exception = 1'b0;
        if (state_reg == DONE) begin
            data_result    = op_mult_reg ? mult_result : div_result;
            data_exception = op_mult_reg ? mult_exc : div_exc;
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// -----------------------------------------------------------------------------
// tb_multdiv_unit
//
// Self-checking bench for multdiv_unit. A table of vectors is applied one op
// at a time; each start pushes its expected result onto a scoreboard queue and
// a negedge monitor pops and compares whenever data_resultRDY is high, also
// checking the 32-cycle latency. Hand-written sequences cover flush by a new
// start, back-to-back start in DONE and asynchronous reset mid-run.
// -----------------------------------------------------------------------------
module tb_multdiv_unit;

    localparam int W = 32;

    logic         clock;
    logic         reset;
    logic         ctrl_MULT;
    logic         ctrl_DIV;
    logic [W-1:0] data_operandA;
    logic [W-1:0] data_operandB;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;
    logic         busy;

    multdiv_unit #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cycle = 0;
    always @(posedge clock) cycle <= cycle + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic         mult;
        logic         div;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         exc;
        string        name;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         exc;
        int           start;
        string        name;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest outstanding op.
    always @(negedge clock) begin
        if (data_resultRDY) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_rdy: strobe with result %h and no op outstanding", data_result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("op %s: result=%h exc=%b latency=%0d", e.name, data_result,
                         data_exception, cycle - e.start);
                check({e.name, "_result"}, data_result, e.res);
                check({e.name, "_exc"}, {31'd0, data_exception}, {31'd0, e.exc});
                check({e.name, "_latency"}, W'(cycle - e.start), W'(32));
            end
        end
    end

    // Called just after a negedge; returns just after the negedge following
    // the start edge, with operands scrambled to show they are not re-read.
    task automatic start_op(input logic m, input logic d, input logic [W-1:0] a,
                            input logic [W-1:0] b, input bit push,
                            input logic [W-1:0] er, input logic ee, input string nm);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        if (push) sb.push_back('{er, ee, cycle, nm});
    endtask

    task automatic wait_rdy(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            if (data_resultRDY) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_timeout: no data_resultRDY within 40 cycles, required 1", nm);
        end
    endtask

    task automatic check_idle_after(input string nm);
        @(negedge clock);
        check({nm, "_busy_after"}, {31'd0, busy}, 32'd0);
        check({nm, "_rdy_after"}, {31'd0, data_resultRDY}, 32'd0);
    endtask

    vec_t vecs[17];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 32'd3,        32'hFFFFFFFC, 32'hFFFFFFF4, 1'b0, "mul_3_m4"};
        vecs[1]  = '{1'b0, 1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, "div_7_m2"};
        vecs[2]  = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, "div_m7_2"};
        vecs[3]  = '{1'b0, 1'b1, 32'd5,        32'd0,        32'd0,        1'b1, "div_5_0"};
        vecs[4]  = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "div_min_m1"};
        vecs[5]  = '{1'b1, 1'b0, 32'h00010000, 32'h00010000, 32'd0,        1'b1, "mul_2p16_sq"};
        vecs[6]  = '{1'b1, 1'b0, 32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 1'b0, "mul_max_1"};
        vecs[7]  = '{1'b1, 1'b0, 32'hFFFFFFFB, 32'hFFFFFFF9, 32'd35,       1'b0, "mul_m5_m7"};
        vecs[8]  = '{1'b1, 1'b0, 32'h80000000, 32'd1,        32'h80000000, 1'b0, "mul_min_1"};
        vecs[9]  = '{1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'd0,        1'b1, "mul_min_min"};
        vecs[10] = '{1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "mul_min_m1"};
        vecs[11] = '{1'b1, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'd1,        1'b1, "mul_max_max"};
        vecs[12] = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        1'b0, "div_m7_m2"};
        vecs[13] = '{1'b0, 1'b1, 32'h80000000, 32'd2,        32'hC0000000, 1'b0, "div_min_2"};
        vecs[14] = '{1'b0, 1'b1, 32'h7FFFFFFF, 32'h80000000, 32'd0,        1'b0, "div_max_min"};
        vecs[15] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'd0,        32'd0,        1'b1, "div_m1_0"};
        vecs[16] = '{1'b1, 1'b1, 32'd5,        32'd3,        32'd15,       1'b0, "both_pulses"};

        reset         = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;

        // Reset state, checked before any clock edge.
        #1 reset = 1'b1;
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("reset_result", data_result, 32'd0);
        check("reset_exc", {31'd0, data_exception}, 32'd0);
        #2 reset = 1'b0;
        @(negedge clock);

        // Table-driven single ops.
        for (int i = 0; i < 17; i++) begin
            start_op(vecs[i].mult, vecs[i].div, vecs[i].a, vecs[i].b, 1'b1,
                     vecs[i].res, vecs[i].exc, vecs[i].name);
            check({vecs[i].name, "_busy_run"}, {31'd0, busy}, 32'd1);
            wait_rdy(vecs[i].name);
            check_idle_after(vecs[i].name);
        end

        // Flush: MULT 6*6 aborted by DIV 100/7 ten cycles later.
        start_op(1'b1, 1'b0, 32'd6, 32'd6, 1'b0, 32'd36, 1'b0, "mul_aborted");
        repeat (9) @(negedge clock);
        start_op(1'b0, 1'b1, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0, "div_after_abort");
        wait_rdy("div_after_abort");
        check_idle_after("div_after_abort");

        // Back-to-back: new op started during the DONE cycle.
        start_op(1'b1, 1'b0, 32'h1234, 32'h10, 1'b1, 32'h12340, 1'b0, "b2b_first");
        wait_rdy("b2b_first");
        start_op(1'b0, 1'b1, 32'd1000, 32'hFFFFFFF6, 1'b1, 32'hFFFFFF9C, 1'b0, "b2b_second");
        check("b2b_busy_held", {31'd0, busy}, 32'd1);
        wait_rdy("b2b_second");
        check_idle_after("b2b_second");

        // Asynchronous reset mid-run.
        start_op(1'b1, 1'b0, 32'd9, 32'd9, 1'b0, 32'd81, 1'b0, "mul_reset");
        repeat (10) @(negedge clock);
        #1 reset = 1'b1;
        #1;
        check("midrun_reset_busy", {31'd0, busy}, 32'd0);
        check("midrun_reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("midrun_reset_result", data_result, 32'd0);
        check("midrun_reset_exc", {31'd0, data_exception}, 32'd0);
        #2 reset = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clock);
                if (data_resultRDY) seen = 1'b1;
            end
            check("no_strobe_after_reset", {31'd0, seen}, 32'd0);
        end
        start_op(1'b1, 1'b0, 32'd2, 32'd3, 1'b1, 32'd6, 1'b0, "mul_2_3_post_reset");
        wait_rdy("mul_2_3_post_reset");
        check_idle_after("mul_2_3_post_reset");

        check("scoreboard_empty", W'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
